// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the 7-segment display path: digit width, the blank
// code the scanner decodes as "segments off", the number of display
// positions, and the state type of the binary-to-BCD converter.
// No ports (package).
// ---------------------------------------------------------------------------
package display_pkg;

   localparam int          DIGIT_W     = 4;
   localparam logic [3:0]  DIGIT_BLANK = 4'hF;
   localparam int          NUM_DIGITS  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// Double-dabble nibble adjust: adds 3 to a BCD nibble that is 5 or more so
// the following left shift carries correctly into the next decimal digit.
// Ports:
//   nib_i  in   DIGIT_W  nibble before adjust
//   nib_o  out  DIGIT_W  nibble after adjust
// ---------------------------------------------------------------------------
module bcd_add3
   import display_pkg::*;
(
   input  logic [DIGIT_W-1:0] nib_i,
   output logic [DIGIT_W-1:0] nib_o
);

   // Legal BCD nibbles top out at 9 -> 12, so the 4-bit sum never wraps.
   assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Iterative double-dabble binary-to-BCD converter feeding the 4-digit
// multiplexed 7-segment scanner. One input bit is processed per clock; the
// displayed digits are only updated once the conversion is complete, so the
// scanner never sees intermediate shift values.
//
// Handshake: a value is accepted on a rising clk edge where in_valid and
// in_ready are both high; in_bin is sampled only at that edge. in_valid
// while in_ready is low is ignored (no queuing). out_valid is a single-cycle
// pulse marking the cycle in which bcd/ovf take their new values.
//
// Ports:
//   clk        in   1          system clock
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          in_bin is valid this cycle
//   in_ready   out  1          converter idle, can accept a value
//   in_bin     in   BIN_W      unsigned binary value
//   out_valid  out  1          bcd/ovf updated this cycle
//   ovf        out  1          last accepted value exceeded 10^DIGITS-1
//   bcd        out  4*DIGITS   digits, [3:0]=ones upward; 4'hF = blank
//   dbg_state  out  2          current FSM state (state_t encoding)
// ---------------------------------------------------------------------------
module bin2bcd_seq
   import display_pkg::*;
#(
   parameter int BIN_W    = 14,
   parameter int DIGITS   = NUM_DIGITS,
   parameter int BLANK_LZ = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [BIN_W-1:0]           in_bin,
   output logic                       out_valid,
   output logic                       ovf,
   output logic [DIGIT_W*DIGITS-1:0]  bcd,
   output logic [1:0]                 dbg_state
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int SR_W  = BIN_W + BCD_W;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam int MAX_VAL = pow10(DIGITS) - 1;

   // Displayed value for zero: ones digit 0, higher digits blank or 0.
   function automatic logic [BCD_W-1:0] bcd_rst_val();
      logic [BCD_W-1:0] v;
      v = '0;
      if (BLANK_LZ != 0)
         for (int i = 1; i < DIGITS; i++) v[i*DIGIT_W +: DIGIT_W] = DIGIT_BLANK;
      return v;
   endfunction

   localparam logic [BCD_W-1:0] BCD_RST = bcd_rst_val();

   state_t            state_q, state_d;
   logic [SR_W-1:0]   sr_q, sr_d, sr_adj, sr_shift;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_pend_q, ovf_pend_d;
   logic              ovf_q, ovf_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_raw, bcd_fmt;
   logic              last_iter;
   logic              lead;

   // One iteration: adjust every BCD nibble in parallel, then shift left.
   assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .nib_i (sr_q  [BIN_W + g*DIGIT_W +: DIGIT_W]),
         .nib_o (sr_adj[BIN_W + g*DIGIT_W +: DIGIT_W])
      );
   end
   assign sr_shift  = {sr_adj[SR_W-2:0], 1'b0};
   assign bcd_raw   = sr_shift[SR_W-1 -: BCD_W];
   assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

   // Overflow substitution and leading-zero blanking, applied to the result
   // of the final iteration so bcd is registered already formatted.
   always_comb begin
      bcd_fmt = bcd_raw;
      lead    = 1'b1;
      if (ovf_pend_q) begin
         bcd_fmt = {DIGITS{DIGIT_BLANK}};
      end else if (BLANK_LZ != 0) begin
         for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (bcd_raw[i*DIGIT_W +: DIGIT_W] == '0))
               bcd_fmt[i*DIGIT_W +: DIGIT_W] = DIGIT_BLANK;
            else
               lead = 1'b0;
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = SHIFT;
         SHIFT:   if (last_iter) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      dbg_state = state_q;
   end

   // Datapath next state
   always_comb begin
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sr_d       = {{BCD_W{1'b0}}, in_bin};
               cnt_d      = '0;
               ovf_pend_d = ({{(32-BIN_W){1'b0}}, in_bin} > 32'(MAX_VAL));
            end
         end
         SHIFT: begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) begin
               bcd_d = bcd_fmt;
               ovf_d = ovf_pend_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q       <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         bcd_q      <= BCD_RST;
         ovf_q      <= 1'b0;
      end else begin
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bcd = bcd_q;
   assign ovf = ovf_q;

endmodule
